// File: rtl/adbg_jsp_apb_host_pkg.sv
// Shared constants for the JTAG serial port register set as seen by the APB host.
package adbg_jsp_pkg;

    localparam int JSP_LSR_DR    = 0;
    localparam int JSP_LSR_THRE  = 5;
    localparam int JSP_DATA_ADDR = 32'h0000_0000;
    localparam int JSP_LSR_ADDR  = 32'h0000_0005;

endpackage

// File: rtl/adbg_jsp_apb_host_if.sv
// APB bus bundle between the JSP host (master) and the JSP register block (slave).
interface adbg_jsp_apb_host_if #(
    parameter int PADDR_SIZE = 8,
    parameter int PDATA_SIZE = 8
);

    logic                  PSEL;
    logic                  PENABLE;
    logic [PADDR_SIZE-1:0] PADDR;
    logic                  PWRITE;
    logic [PDATA_SIZE-1:0] PWDATA;
    logic [PDATA_SIZE-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/adbg_jsp_apb_host.sv
// APB initiator that polls the JSP LSR and moves bytes between RBR/THR and a
// valid/ready byte-stream interface.
module adbg_jsp_apb_host
    import adbg_jsp_pkg::*;
#(
    parameter int                    PADDR_SIZE = 8,
    parameter int                    PDATA_SIZE = 8,
    parameter logic [PADDR_SIZE-1:0] DATA_ADDR  = PADDR_SIZE'(JSP_DATA_ADDR),
    parameter logic [PADDR_SIZE-1:0] LSR_ADDR   = PADDR_SIZE'(JSP_LSR_ADDR),
    parameter int                    POLL_DLY   = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    adbg_jsp_apb_host_if.master        apb,
    input  logic [7:0]                 tx_data_i,
    input  logic                       tx_valid_i,
    output logic                       tx_ready_o,
    output logic [7:0]                 rx_data_o,
    output logic                       rx_valid_o,
    input  logic                       rx_ready_i,
    output logic                       err_o
);

    localparam int                CNT_W      = (POLL_DLY > 1) ? $clog2(POLL_DLY) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(POLL_DLY - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};

    localparam logic [2:0] ST_WAIT  = 3'd0;
    localparam logic [2:0] ST_LSR_S = 3'd1;
    localparam logic [2:0] ST_LSR_A = 3'd2;
    localparam logic [2:0] ST_RD_S  = 3'd3;
    localparam logic [2:0] ST_RD_A  = 3'd4;
    localparam logic [2:0] ST_WR_S  = 3'd5;
    localparam logic [2:0] ST_WR_A  = 3'd6;

    logic [2:0]            state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  rr_q,       rr_d;
    logic                  psel_q,     psel_d;
    logic                  penable_q,  penable_d;
    logic [PADDR_SIZE-1:0] paddr_q,    paddr_d;
    logic                  pwrite_q,   pwrite_d;
    logic [PDATA_SIZE-1:0] pwdata_q,   pwdata_d;
    logic [7:0]            rx_data_q,  rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  err_q,      err_d;
    logic                  rx_ok_s,    tx_ok_s;

    // Next-state, bus and stream-side register computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        rx_data_d  = rx_data_q;
        tx_ready_d = 1'b0;
        err_d      = err_q;
        rx_ok_s    = apb.PRDATA[JSP_LSR_DR]   & ~rx_valid_q;
        tx_ok_s    = apb.PRDATA[JSP_LSR_THRE] & tx_valid_i;

        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_LSR_S;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_LSR_S: state_d = ST_LSR_A;
            ST_LSR_A: begin
                if (!apb.PREADY) begin
                    state_d = ST_LSR_A;
                end else if (apb.PSLVERR) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_RELOAD;
                end else if (rx_ok_s && (!tx_ok_s || !rr_q)) begin
                    state_d = ST_RD_S;
                end else if (tx_ok_s) begin
                    state_d = ST_WR_S;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_RELOAD;
                end
            end
            ST_RD_S: state_d = ST_RD_A;
            ST_RD_A: begin
                if (!apb.PREADY) begin
                    state_d = ST_RD_A;
                end else if (apb.PSLVERR) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    rx_data_d  = apb.PRDATA[7:0];
                    rx_valid_d = 1'b1;
                    rr_d       = ~rr_q;
                    state_d    = ST_LSR_S;
                end
            end
            // A producer that withdrew its byte abandons the write before any access phase.
            ST_WR_S: begin
                if (tx_valid_i) begin
                    state_d = ST_WR_A;
                end else begin
                    state_d = ST_LSR_S;
                end
            end
            ST_WR_A: begin
                if (!apb.PREADY) begin
                    state_d = ST_WR_A;
                end else if (apb.PSLVERR) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    tx_ready_d = 1'b1;
                    rr_d       = ~rr_q;
                    state_d    = ST_LSR_S;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Bus outputs are derived from the state being entered so they come straight from flops.
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        case (state_d)
            ST_WAIT: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
            end
            ST_LSR_S: begin
                psel_d    = 1'b1;
                penable_d = 1'b0;
                paddr_d   = LSR_ADDR;
                pwrite_d  = 1'b0;
            end
            ST_RD_S: begin
                psel_d    = 1'b1;
                penable_d = 1'b0;
                paddr_d   = DATA_ADDR;
                pwrite_d  = 1'b0;
            end
            ST_WR_S: begin
                psel_d    = 1'b1;
                penable_d = 1'b0;
                paddr_d   = DATA_ADDR;
                pwrite_d  = 1'b1;
                pwdata_d  = PDATA_SIZE'(tx_data_i);
            end
            ST_LSR_A, ST_RD_A, ST_WR_A: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
            end
        endcase
    end

    // State, poll counter, bus and stream registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= ST_WAIT;
            cnt_q      <= CNT_ZERO;
            rr_q       <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= {PADDR_SIZE{1'b0}};
            pwrite_q   <= 1'b0;
            pwdata_q   <= {PDATA_SIZE{1'b0}};
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            err_q      <= err_d;
        end
    end

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PWDATA  = pwdata_q;
    assign tx_ready_o  = tx_ready_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign err_o       = err_q;

endmodule
